apb_master_mux: RTL and testbench
=================================

# apb_master_mux

Parametrised APB master that turns a valid/ready request into a two-phase APB transfer on one of `NUM_SLAVES` peripherals. It decodes the slave from the upper address bits, drives a one-hot `psel`, and muxes the return channel from the addressed slave. It also aborts hung transfers after a wait-state timeout. It sits between a bus-side request source and the peripheral APB fabric, and succeeds the fixed 4-bit-address / 8-bit-data, single-slave master.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte address width, at least `$clog2(NUM_SLAVES)+1`.
- `DATA_WIDTH`, default 32: data width.
- `NUM_SLAVES`, default 4: number of peripherals; a power of two, at least 2. `SW = $clog2(NUM_SLAVES)`.
- `TIMEOUT`, default 15: maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout.

Ports (name, direction, width, meaning):
- `pclk`, in, 1: clock; all logic on the rising edge.
- `presetn`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_WIDTH: target address; bits `[ADDR_WIDTH-1 -: SW]` select the slave.
- `req_wdata`, in, DATA_WIDTH: write data.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, DATA_WIDTH: read data; 0 for writes and on timeout.
- `rsp_err`, out, 1: slave error or timeout; valid with `rsp_valid`.
- `paddr`, out, ADDR_WIDTH: APB address.
- `pwrite`, out, 1: APB direction.
- `pwdata`, out, DATA_WIDTH: APB write data.
- `psel`, out, NUM_SLAVES: one-hot slave select.
- `penable`, out, 1: APB access phase.
- `pready`, in, NUM_SLAVES: per-slave ready.
- `prdata`, in, NUM_SLAVES*DATA_WIDTH: slave k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `pslverr`, in, NUM_SLAVES: per-slave error.

## Operation
- All outputs are registered except `req_ready`, which is `(state==IDLE)`.
- **IDLE**
  - `psel=0`, `penable=0`; `paddr`, `pwrite` and `pwdata` hold their last values.
  - On `req_valid`, latch `req_addr`, `req_write` and `req_wdata` into `paddr`, `pwrite` and `pwdata`. Latch the slave index `sel`. Go to SETUP.
- **SETUP**
  - `psel[sel]=1`, `penable=0`. Clear the wait counter.
  - Next state is always ACCESS.
- **ACCESS**
  - `psel[sel]=1`, `penable=1`. Only `pready[sel]`, `pslverr[sel]` and `prdata` slice `sel` are observed; other slaves are ignored.
  - If `pready[sel]=1`:
    - `rsp_valid=1` next cycle.
    - `rsp_err = pslverr[sel]`.
    - `rsp_rdata` = `prdata` slice if `!pwrite`, else 0.
    - Go to IDLE.
  - Else if `TIMEOUT!=0` and the wait counter equals `TIMEOUT`:
    - `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
    - Go to IDLE.
  - Else increment the wait counter (width `$clog2(TIMEOUT+1)`, minimum 1) and stay in ACCESS.
- `paddr`, `pwrite`, `pwdata` and `psel` stay constant from SETUP through the end of ACCESS. Request inputs are not sampled outside IDLE.
- `rsp_rdata` and `rsp_err` hold until the next completion. `rsp_valid` is low at all other times.
- Reset (`presetn=0` at an edge):
  - state goes to IDLE; `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err` and the wait counter all go to 0.
  - A transfer interrupted mid-flight produces no `rsp_valid`.
- `psel` is never multi-hot. `penable` is never high without `psel`.

## Timing
- Request accepted at edge N (IDLE, `req_valid=1`):
  - SETUP during cycle N+1.
  - ACCESS from cycle N+2.
- Zero wait states: `pready` high in cycle N+2, so `rsp_valid` is high in cycle N+3 and `req_ready` is high in N+3.
- Peak throughput: one transfer per 3 cycles. A request held high during the `rsp_valid` cycle is accepted in that same cycle.
- W wait states (W < TIMEOUT): ACCESS lasts W+1 cycles; `rsp_valid` arrives W+1 cycles after ACCESS entry.
- Timeout: after exactly TIMEOUT+1 ACCESS cycles with `pready[sel]` low, the abort is taken. `rsp_valid` follows in the next cycle.
- `pready[sel]` rising in the same cycle the counter reaches TIMEOUT: this is a normal completion, not a timeout.

## Test plan
- Reset with `req_valid=1`:
  - Hold `presetn=0` for 3 cycles. All outputs must be 0 and `req_ready=1` after release.
  - Apply reset during ACCESS: `psel`/`penable` must be 0 next cycle and `rsp_valid` must never pulse.
- Zero-wait write:
  - Stimulus: addr 0x45 (slave 1 when ADDR_WIDTH=8, NUM_SLAVES=4), wdata 0xDEADBEEF.
  - Required: `psel=4'b0010` for 2 cycles; `penable` high in the 2nd; `rsp_valid` 3 cycles after accept; `rsp_err=0`; `rsp_rdata=0`.
- Read with 3 wait states from slave 3:
  - Stimulus: addr 0xC0; slave 3 returns `prdata=0x12345678`. Slave 0 simultaneously drives `pready=1`, `prdata=0xFFFFFFFF`.
  - Required: `rsp_rdata=0x12345678`; ACCESS lasts 4 cycles.
- Slave error: read slave 2 (addr 0x80) with `pslverr[2]=1` together with `pready[2]=1`. Required: `rsp_valid=1`, `rsp_err=1`.
- Timeout:
  - With TIMEOUT=15, slave 0 never asserts `pready`. Required: abort after 16 ACCESS cycles with `rsp_err=1`, `rsp_rdata=0`, then IDLE.
  - Repeat with `pready` rising in the 16th ACCESS cycle. Required: normal completion with `rsp_err=0`.
- Back-to-back: hold `req_valid` high for 4 requests. Required: 4 `rsp_valid` pulses 3 cycles apart and each address/data pair reproduced on APB in order.

Source files
------------

// File: rtl/apb_master_mux.sv
// rtl/apb_master_mux.sv - valid/ready to APB master with slave decode, return mux and wait-state timeout
module apb_master_mux #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SW-1:0]         r_sel;
  logic [CW-1:0]         r_wait;
  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [SW-1:0]         w_req_sel;
  logic                  w_ready_sel;
  logic                  w_err_sel;
  logic [DATA_WIDTH-1:0] w_rdata_sel;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_abort;

  assign w_req_sel   = req_addr[ADDR_WIDTH-1 -: SW];
  assign w_ready_sel = pready[r_sel];
  assign w_err_sel   = pslverr[r_sel];
  assign w_rdata_sel = prdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_timeout   = (TIMEOUT != 0) && (r_wait == TO_VAL);
  // A ready slave always wins over a timeout landing in the same cycle.
  assign w_done      = (r_state == S_ACCESS) && w_ready_sel;
  assign w_abort     = (r_state == S_ACCESS) && !w_ready_sel && w_timeout;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_sel       <= '0;
      r_wait      <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_sel    <= w_req_sel;
            r_psel   <= NUM_SLAVES'(1) << w_req_sel;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err_sel;
            r_rsp_rdata <= r_pwrite ? '0 : w_rdata_sel;
            r_psel      <= '0;
            r_penable   <= 1'b0;
          end else if (w_abort) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign psel      = r_psel;
  assign penable   = r_penable;

endmodule

// File: tb/tb_apb_master_mux.sv
// tb/tb_apb_master_mux.sv - directed self-checking bench for apb_master_mux
module tb_apb_master_mux;

  logic         pclk;
  logic         presetn;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [7:0]   req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [7:0]   paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   psel;
  logic         penable;
  logic [3:0]   pready;
  logic [127:0] prdata;
  logic [3:0]   pslverr;

  int checks;
  int failures;

  apb_master_mux #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_SLAVES(4),
    .TIMEOUT(15)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .psel(psel),
    .penable(penable),
    .pready(pready),
    .prdata(prdata),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'hFF;
    req_wdata = 32'hFFFF_FFFF;
    pready    = 4'hF;
    pslverr   = 4'hF;
    prdata    = {128{1'b1}};
    repeat (3) tick();
    checks++;
    if ({psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got psel=%h penable=%b paddr=%h pwrite=%b pwdata=%h rsp_valid=%b rsp_rdata=%h rsp_err=%b, want all 0",
               psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b0;
    pready    = 4'h0;
    pslverr   = 4'h0;
    prdata    = '0;
    presetn   = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || psel !== 4'h0) begin
      failures++;
      $display("FAIL reset_release_idle: got req_ready=%b psel=%h want 1/0", req_ready, psel);
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h04;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (psel !== 4'b0001 || penable !== 1'b1) begin
      failures++;
      $display("FAIL midreset_access: got psel=%b penable=%b want 0001/1", psel, penable);
    end
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    checks++;
    if (psel !== 4'h0 || penable !== 1'b0) begin
      failures++;
      $display("FAIL midreset_cleared: got psel=%b penable=%b want 0000/0", psel, penable);
    end
    pulses = (rsp_valid === 1'b1) ? 1 : 0;
    pready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid === 1'b1) pulses++;
    end
    pready = 4'h0;
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp: got %0d rsp_valid pulses want 0", pulses);
    end
  endtask

  task automatic test_zero_wait_write();
    pready    = 4'b0010;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h45;
    req_wdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    checks++;
    if (psel !== 4'b0010 || penable !== 1'b0 || paddr !== 8'h45 || pwrite !== 1'b1 ||
        pwdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL zw_setup: got psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h req_ready=%b want 0010/0/45/1/deadbeef/0",
               psel, penable, paddr, pwrite, pwdata, req_ready);
    end
    tick();
    checks++;
    if (psel !== 4'b0010 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_access: got psel=%b penable=%b rsp_valid=%b want 0010/1/0", psel, penable, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 4'h0 ||
        penable !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL zw_rsp: got rsp_valid=%b rsp_err=%b rsp_rdata=%h psel=%b penable=%b req_ready=%b want 1/0/0/0000/0/1",
               rsp_valid, rsp_err, rsp_rdata, psel, penable, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL zw_rsp_pulse: got rsp_valid=%b want 0", rsp_valid);
    end
    pready = 4'h0;
  endtask

  task automatic test_wait_read();
    int access_cycles;
    access_cycles = 0;
    pready           = 4'b0001;
    prdata[31:0]     = 32'hFFFF_FFFF;
    prdata[127:96]   = 32'h1234_5678;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'hC0;
    req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    checks++;
    if (psel !== 4'b1000 || penable !== 1'b0) begin
      failures++;
      $display("FAIL wr_setup: got psel=%b penable=%b want 1000/0", psel, penable);
    end
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (penable === 1'b1 && psel === 4'b1000 && rsp_valid === 1'b0) access_cycles++;
      if (k == 4) pready[3] = 1'b1;
      tick();
    end
    checks++;
    if (access_cycles != 4 || penable !== 1'b0) begin
      failures++;
      $display("FAIL wr_access_len: got %0d access cycles penable_after=%b want 4/0", access_cycles, penable);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_rsp: got rsp_valid=%b rsp_rdata=%h rsp_err=%b want 1/12345678/0", rsp_valid, rsp_rdata, rsp_err);
    end
    pready = 4'h0;
    prdata = '0;
    tick();
  endtask

  task automatic test_slave_error();
    pready          = 4'b0100;
    pslverr         = 4'b0100;
    prdata[95:64]   = 32'hA5A5_A5A5;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h80;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL slverr_rsp: got rsp_valid=%b rsp_err=%b rsp_rdata=%h want 1/1/a5a5a5a5", rsp_valid, rsp_err, rsp_rdata);
    end
    pready  = 4'h0;
    pslverr = 4'h0;
    prdata  = '0;
    tick();
  endtask

  task automatic run_timeout(input bit late_ready, input bit want_err, input logic [31:0] want_rdata,
                             input string name);
    int early;
    early = 0;
    pready       = 4'h0;
    prdata[31:0] = 32'h0000_0055;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (rsp_valid !== 1'b0 || penable !== 1'b1) early++;
      if (late_ready && k == 16) pready[0] = 1'b1;
      tick();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL %s_early: got %0d cycles without ACCESS or with rsp_valid, want 0", name, early);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== want_err || rsp_rdata !== want_rdata ||
        req_ready !== 1'b1 || psel !== 4'h0) begin
      failures++;
      $display("FAIL %s_rsp: got rsp_valid=%b rsp_err=%b rsp_rdata=%h req_ready=%b psel=%b want 1/%b/%h/1/0000",
               name, rsp_valid, rsp_err, rsp_rdata, req_ready, psel, want_err, want_rdata);
    end
    pready = 4'h0;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== want_err) begin
      failures++;
      $display("FAIL %s_hold: got rsp_valid=%b rsp_err=%b want 0/%b", name, rsp_valid, rsp_err, want_err);
    end
  endtask

  task automatic test_timeout();
    run_timeout(1'b0, 1'b1, 32'h0, "timeout_abort");
    run_timeout(1'b1, 1'b0, 32'h0000_0055, "timeout_late_ready");
    prdata = '0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [4];
    logic [31:0] datas [4];
    int idx;
    int setups_ok;
    int rsp_count;
    int rsp_cycle [4];
    int multi_hot;
    addrs[0] = 8'h04; datas[0] = 32'h1111_0001;
    addrs[1] = 8'h48; datas[1] = 32'h2222_0002;
    addrs[2] = 8'h8C; datas[2] = 32'h3333_0003;
    addrs[3] = 8'hF0; datas[3] = 32'h4444_0004;
    idx = 0; setups_ok = 0; rsp_count = 0; multi_hot = 0;
    pready    = 4'hF;
    pslverr   = 4'h0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addrs[0];
    req_wdata = datas[0];
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (!$onehot0(psel) || (penable && psel == 4'h0)) multi_hot++;
      if (rsp_valid === 1'b1 && rsp_count < 4) begin
        rsp_cycle[rsp_count] = cyc;
        rsp_count++;
      end
      if (psel !== 4'h0 && penable === 1'b0 && idx < 4) begin
        if (paddr === addrs[idx] && pwdata === datas[idx] && pwrite === 1'b1 &&
            psel === (4'b0001 << addrs[idx][7:6])) setups_ok++;
        else $display("FAIL b2b_setup%0d: got paddr=%h pwdata=%h psel=%b want %h/%h", idx, paddr, pwdata, psel, addrs[idx], datas[idx]);
        idx++;
        if (idx < 4) begin
          req_addr  = addrs[idx];
          req_wdata = datas[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    checks++;
    if (setups_ok != 4) begin
      failures++;
      $display("FAIL b2b_order: got %0d matching transfers want 4", setups_ok);
    end
    checks++;
    if (rsp_count != 4 || rsp_cycle[0] != 3 || rsp_cycle[1] != 6 || rsp_cycle[2] != 9 || rsp_cycle[3] != 12) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d pulses at %0d,%0d,%0d,%0d want 4 at 3,6,9,12",
               rsp_count, rsp_cycle[0], rsp_cycle[1], rsp_cycle[2], rsp_cycle[3]);
    end
    checks++;
    if (multi_hot != 0) begin
      failures++;
      $display("FAIL b2b_psel_onehot: got %0d bad cycles want 0", multi_hot);
    end
    pready = 4'h0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    presetn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = '0;
    prdata    = '0;
    pslverr   = '0;
    test_reset();
    test_reset_mid_access();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
